vga_scan_engine: RTL and testbench

Parametrised VGA scan engine. It generates programmable horizontal and vertical timing from a single system clock with a pixel clock-enable, and issues framebuffer read addresses. It applies integer (power-of-two) pixel replication and outputs sync, data-enable and 12-bit RGB. Sync and data-enable are delay-matched to the framebuffer read latency. It sits between the display RAM read port and the board VGA pins, and replaces fixed-mode timing logic.

---
 rtl/vga_scan_engine.sv | 164 ++++++++++++++++
 tb/tb_vga_scan_engine.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_scan_engine.sv
// VGA scan engine: programmable sync timing, scaled framebuffer addressing and
// sync/DE/RGB outputs delay-matched to the framebuffer read latency.
module vga_scan_engine #(
  parameter int          H_ACTIVE   = 640,
  parameter int          H_FP       = 16,
  parameter int          H_SYNC     = 96,
  parameter int          H_BP       = 48,
  parameter int          V_ACTIVE   = 480,
  parameter int          V_FP       = 10,
  parameter int          V_SYNC     = 2,
  parameter int          V_BP       = 33,
  parameter bit          HS_POL     = 1'b0,
  parameter bit          VS_POL     = 1'b0,
  parameter int          FB_W       = 320,
  parameter int          FB_H       = 240,
  parameter int          SCALE_LOG2 = 1,
  parameter int          RD_LAT     = 1,
  parameter int          ADDR_W     = 19,
  parameter logic [11:0] BORDER     = 12'h000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pix_ce,
  output logic [ADDR_W-1:0] fb_addr,
  output logic              fb_en,
  input  logic [11:0]       fb_data,
  output logic              hsync,
  output logic              vsync,
  output logic              de,
  output logic [3:0]        vgared,
  output logic [3:0]        vgagreen,
  output logic [3:0]        vgablue,
  output logic              frame_start
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW       = $clog2(H_TOTAL);
  localparam int VW       = $clog2(V_TOTAL);
  localparam int H_WIN    = FB_W << SCALE_LOG2;
  localparam int V_WIN    = FB_H << SCALE_LOG2;
  localparam int SMASK    = (1 << SCALE_LOG2) - 1;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int VS_START = V_ACTIVE + V_FP;

  localparam int F_ACT = 0;
  localparam int F_WIN = 1;
  localparam int F_HS  = 2;
  localparam int F_VS  = 3;
  localparam int F_FS  = 4;

  logic [HW-1:0]     h_q, h_d;
  logic [VW-1:0]     v_q, v_d;
  logic [ADDR_W-1:0] lineBase_q, lineBase_d;
  logic [ADDR_W-1:0] colOff_q, colOff_d;
  logic [ADDR_W-1:0] fbAddr_q;
  logic              fbEn_q;
  logic [4:0]        flags_q, flags_d;
  logic [4:0]        pipe_q [RD_LAT];
  logic [4:0]        outFlags;
  logic [31:0]       hx, vx;
  logic              hWrap, vWrap, rawActive, rawWindow;
  logic              hsync_q, vsync_q, de_q, fs_q;
  logic [11:0]       rgb_q;

  always_comb begin
    hx        = 32'(h_q);
    vx        = 32'(v_q);
    hWrap     = (hx == H_TOTAL - 1);
    vWrap     = (vx == V_TOTAL - 1);
    rawActive = (hx < H_ACTIVE) && (vx < V_ACTIVE);
    rawWindow = rawActive && (hx < H_WIN) && (vx < V_WIN);
    flags_d   = '0;
    flags_d[F_ACT] = rawActive;
    flags_d[F_WIN] = rawWindow;
    flags_d[F_HS]  = (hx >= HS_START) && (hx < HS_START + H_SYNC);
    flags_d[F_VS]  = (vx >= VS_START) && (vx < VS_START + V_SYNC);
    flags_d[F_FS]  = (hx == 0) && (vx == 0);

    h_d = hWrap ? '0 : h_q + 1'b1;
    v_d = v_q;
    if (hWrap) v_d = vWrap ? '0 : v_q + 1'b1;

    // Column offset steps once per replicated source pixel; line base steps
    // once per replicated source line, so no multiplier is needed.
    colOff_d = colOff_q;
    if (hWrap)
      colOff_d = '0;
    else if ((hx < H_WIN) && ((hx & SMASK) == SMASK))
      colOff_d = colOff_q + 1'b1;

    lineBase_d = lineBase_q;
    if (hWrap) begin
      if (vWrap)
        lineBase_d = '0;
      else if ((vx < V_WIN) && ((vx & SMASK) == SMASK))
        lineBase_d = lineBase_q + ADDR_W'(FB_W);
    end
  end

  // Stage 0: fb_addr/fb_en describe the pixel consumed on this pix_ce edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_q        <= '0;
      v_q        <= '0;
      lineBase_q <= '0;
      colOff_q   <= '0;
      fbAddr_q   <= '0;
      fbEn_q     <= 1'b0;
      flags_q    <= '0;
    end else if (pix_ce) begin
      h_q        <= h_d;
      v_q        <= v_d;
      lineBase_q <= lineBase_d;
      colOff_q   <= colOff_d;
      fbEn_q     <= rawWindow;
      if (rawWindow) fbAddr_q <= lineBase_q + colOff_q;
      flags_q    <= flags_d;
    end else begin
      flags_q[F_FS] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RD_LAT; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= flags_q;
      for (int i = 1; i < RD_LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign outFlags = pipe_q[RD_LAT-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      hsync_q <= ~HS_POL;
      vsync_q <= ~VS_POL;
      de_q    <= 1'b0;
      fs_q    <= 1'b0;
      rgb_q   <= '0;
    end else begin
      hsync_q <= outFlags[F_HS] ? HS_POL : ~HS_POL;
      vsync_q <= outFlags[F_VS] ? VS_POL : ~VS_POL;
      de_q    <= outFlags[F_ACT];
      fs_q    <= outFlags[F_FS];
      if (!outFlags[F_ACT])
        rgb_q <= '0;
      else if (outFlags[F_WIN])
        rgb_q <= fb_data;
      else
        rgb_q <= BORDER;
    end
  end

  assign fb_addr     = fbAddr_q;
  assign fb_en       = fbEn_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign frame_start = fs_q;
  assign {vgared, vgagreen, vgablue} = rgb_q;

endmodule

// File: tb/tb_vga_scan_engine.sv
// Testbench for vga_scan_engine: small 14x7 raster with a scoreboard fed by a
// pixel-level reference model, plus a continuous pix_ce instance.
module tb_vga_scan_engine;

  localparam int HT  = 14;
  localparam int VT  = 7;
  localparam int FBW = 3;
  localparam logic [11:0] BRD = 12'hF0F;
  localparam logic [15:0] CLEARED = {1'b0, 1'b1, 1'b1, 1'b0, 12'h000};

  logic        clk = 1'b0;
  logic        rst, pix_ce;
  logic [18:0] fb_addr;
  logic        fb_en;
  logic [11:0] fb_data;
  logic        hsync, vsync, de, frame_start;
  logic [3:0]  vgared, vgagreen, vgablue;

  logic        rst2;
  logic [18:0] fb_addr2;
  logic        fb_en2, hsync2, vsync2, de2, frame_start2;
  logic [3:0]  red2, green2, blue2;

  always #5 clk = ~clk;

  vga_scan_engine #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .FB_W(3), .FB_H(2), .SCALE_LOG2(1),
    .RD_LAT(2), .ADDR_W(19), .BORDER(12'hF0F)
  ) dut (
    .clk(clk), .rst(rst), .pix_ce(pix_ce), .fb_addr(fb_addr), .fb_en(fb_en),
    .fb_data(fb_data), .hsync(hsync), .vsync(vsync), .de(de),
    .vgared(vgared), .vgagreen(vgagreen), .vgablue(vgablue),
    .frame_start(frame_start)
  );

  vga_scan_engine #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .FB_W(3), .FB_H(2), .SCALE_LOG2(1),
    .RD_LAT(1), .ADDR_W(19), .BORDER(12'hF0F)
  ) dut2 (
    .clk(clk), .rst(rst2), .pix_ce(1'b1), .fb_addr(fb_addr2), .fb_en(fb_en2),
    .fb_data(12'h000), .hsync(hsync2), .vsync(vsync2), .de(de2),
    .vgared(red2), .vgagreen(green2), .vgablue(blue2),
    .frame_start(frame_start2)
  );

  // Framebuffer RAM with a two-cycle read latency
  logic [11:0] mem [64];
  logic [11:0] ramStage;
  always @(posedge clk) begin
    ramStage <= mem[fb_addr[5:0]];
    fb_data  <= ramStage;
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model in terms of raster position (x,y)
  function automatic bit inWin(int x, int y);
    return (x < 6) && (y < 4);
  endfunction

  function automatic int addrOf(int x, int y);
    return (y / 2) * FBW + (x / 2);
  endfunction

  function automatic logic [15:0] pixelOut(int x, int y);
    logic        act;
    logic [11:0] rgb;
    act = (x < 8) && (y < 4);
    if (!act)            rgb = 12'h000;
    else if (inWin(x, y)) rgb = mem[addrOf(x, y)];
    else                  rgb = BRD;
    return {(x == 0 && y == 0), !(x >= 10 && x < 12), !(y == 5), act, rgb};
  endfunction

  logic [15:0] expQ[$];
  logic [15:0] held;
  logic [18:0] expAddr;
  logic        expEn;
  bit          modelOn = 0;
  int          mx = 0;
  int          my = 0;

  // Model: each edge pushes the output expected RD_LAT+1 edges later
  initial forever begin
    logic [15:0] cur;
    @(posedge clk);
    modelOn = 1;
    if (rst) begin
      for (int i = 0; i < expQ.size(); i++) expQ[i] = CLEARED;
      expQ.push_back(CLEARED);
      mx = 0; my = 0; expAddr = '0; expEn = 1'b0; held = CLEARED;
    end else if (pix_ce) begin
      cur   = pixelOut(mx, my);
      expEn = inWin(mx, my);
      if (expEn) expAddr = 19'(addrOf(mx, my));
      expQ.push_back(cur);
      held = cur;
      held[15] = 1'b0;
      mx++;
      if (mx == HT) begin
        mx = 0; my++;
        if (my == VT) my = 0;
      end
    end else begin
      expQ.push_back(held);
    end
  end

  int cyc = 0;
  int fsTimes[$];

  // Monitor
  initial forever begin
    logic [15:0] e;
    @(negedge clk);
    cyc++;
    if (expQ.size() == 4) begin
      e = expQ.pop_front();
      checkOutput("out{fs,hs,vs,de,rgb}",
                  32'({frame_start, hsync, vsync, de, vgared, vgagreen, vgablue}),
                  32'(e));
    end
    if (modelOn) begin
      checkOutput("fb_en", 32'(fb_en), 32'(expEn));
      checkOutput("fb_addr", 32'(fb_addr), 32'(expAddr));
    end
    if (frame_start === 1'b1) fsTimes.push_back(cyc);
  end

  int cyc2 = 0;
  int lastFs2 = -1;
  int enRise2[$];
  logic prevEn2 = 1'b0;
  logic prevDe2 = 1'b0;

  // Continuous pix_ce instance: frame period and de-to-fb_en lag
  initial forever begin
    @(negedge clk);
    cyc2++;
    if (!rst2) begin
      if (fb_en2 && !prevEn2) enRise2.push_back(cyc2);
      if (de2 && !prevDe2) begin
        if (enRise2.size() == 0) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL de2_lag: de rose at cycle %0d with no fb_en rise pending", cyc2);
        end else begin
          checkOutput("de2_lag", 32'(cyc2 - enRise2.pop_front()), 32'd2);
        end
      end
      if (frame_start2 === 1'b1) begin
        if (lastFs2 >= 0) checkOutput("frame2_period", 32'(cyc2 - lastFs2), 32'd98);
        lastFs2 = cyc2;
      end
      prevEn2 = fb_en2;
      prevDe2 = de2;
    end
  end

  initial begin
    rst2 = 1'b1;
    repeat (3) @(negedge clk);
    rst2 = 1'b0;
  end

  task automatic applyStimulus(input bit ce, input bit r);
    @(negedge clk);
    pix_ce = ce;
    rst    = r;
  endtask

  initial begin
    int fsBase;
    int i;
    bit found;
    rst = 1'b1;
    pix_ce = 1'b0;
    for (int k = 0; k < 64; k++) mem[k] = 12'(k);

    repeat (4) applyStimulus(0, 1);
    fsBase = fsTimes.size();
    i = 0;
    for (int k = 0; k < 2 * HT * VT * 3; k++) begin
      applyStimulus(i % 3 == 0, 0);
      i++;
    end
    @(posedge clk);
    checkOutput("frame_start_count", 32'(fsTimes.size() - fsBase), 32'd2);
    if (fsTimes.size() - fsBase >= 2)
      checkOutput("frame_start_spacing",
                  32'(fsTimes[fsTimes.size()-1] - fsTimes[fsTimes.size()-2]), 32'd294);

    // Mid-frame reset once the scan reaches line 3, x=4
    found = 0;
    for (int k = 0; k < 1000 && !found; k++) begin
      if (mx == 4 && my == 3) found = 1;
      else begin
        applyStimulus(i % 3 == 0, 0);
        i++;
      end
    end
    checkOutput("midreset_reached", 32'(found), 32'd1);
    applyStimulus(0, 1);
    for (int k = 0; k < HT * VT * 3 + 30; k++) applyStimulus(k % 3 == 0, 0);

    // Random framebuffer contents, random pix_ce spacing and random resets
    applyStimulus(0, 1);
    for (int k = 0; k < 64; k++) mem[k] = 12'($urandom);
    repeat (4) applyStimulus(0, 1);
    i = 0;
    while (i < 3000) begin
      int gap;
      gap = $urandom_range(3, 6);
      applyStimulus(1, 0);
      for (int j = 1; j < gap; j++) applyStimulus(0, 0);
      i += gap;
      if ($urandom_range(0, 59) == 0) begin
        applyStimulus(0, 1);
        i++;
      end
    end
    repeat (6) applyStimulus(0, 0);
    @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
